// File: rtl/ascon_dec_release_buffer_if.sv
// Handshake bundle between the decrypting core, the release buffer and the consumer.
// master drives start/pt/tag/out_ready; slave (the buffer) drives pt_ready, out_* and auth status.
interface ascon_dec_release_buffer_if;
  logic         start;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic [4:0]   pt_bytes;
  logic         pt_last;
  logic         tag_valid;
  logic [127:0] tag_calc;
  logic [127:0] tag_rx;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;
  logic         out_last;
  logic         auth_done;
  logic         auth_ok;
  logic         err_overflow;

  modport master (
    output start, pt_valid, pt_data, pt_bytes, pt_last,
    output tag_valid, tag_calc, tag_rx, out_ready,
    input  pt_ready, out_valid, out_data, out_bytes, out_last,
    input  auth_done, auth_ok, err_overflow
  );

  modport slave (
    input  start, pt_valid, pt_data, pt_bytes, pt_last,
    input  tag_valid, tag_calc, tag_rx, out_ready,
    output pt_ready, out_valid, out_data, out_bytes, out_last,
    output auth_done, auth_ok, err_overflow
  );
endinterface

// File: rtl/ascon_dec_release_buffer.sv
// Holds decrypted plaintext until the tag verifies, then releases it in order.
// Ports: clk, rst (async high), bus (slave): start, pt_*, tag_*, out_*, auth_*, err_overflow.
module ascon_dec_release_buffer #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  ascon_dec_release_buffer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, COLLECT, WAIT_TAG, RELEASE, FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          auth_done_q;
  logic          auth_ok_q;
  logic          err_q;

  logic [127:0]  mem_data [DEPTH];
  logic [4:0]    mem_bytes [DEPTH];
  logic          mem_last [DEPTH];

  logic pt_ready_w;
  logic pt_fire;
  logic out_valid_w;
  logic out_fire;
  logic tag_diff;
  logic full;

  assign full        = (count == CW'(DEPTH));
  assign pt_ready_w  = (state == COLLECT) && !full;
  // start wins over any same-cycle handshake
  assign pt_fire     = bus.pt_valid && pt_ready_w && !bus.start;
  assign out_valid_w = (state == RELEASE) && (count != '0);
  assign out_fire    = out_valid_w && bus.out_ready && !bus.start;
  // full-width compare, no early exit
  assign tag_diff    = |(bus.tag_calc ^ bus.tag_rx);

  assign bus.pt_ready     = pt_ready_w;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_data     = out_valid_w ? mem_data[rd_ptr] : '0;
  assign bus.out_bytes    = out_valid_w ? mem_bytes[rd_ptr] : '0;
  assign bus.out_last     = out_valid_w & mem_last[rd_ptr];
  assign bus.auth_done    = auth_done_q;
  assign bus.auth_ok      = auth_ok_q;
  assign bus.err_overflow = err_q;

  always_ff @(posedge clk) begin
    if (pt_fire) begin
      mem_data[wr_ptr]  <= bus.pt_data;
      mem_bytes[wr_ptr] <= bus.pt_bytes;
      mem_last[wr_ptr]  <= bus.pt_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      auth_done_q <= 1'b0;
      auth_ok_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      auth_done_q <= 1'b0;
      if (bus.start && state != FAIL) begin
        state     <= COLLECT;
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        auth_ok_q <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          COLLECT: begin
            if (pt_fire) begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count + 1'b1;
              if (bus.pt_last)
                state <= WAIT_TAG;
            end else if (bus.pt_valid && full) begin
              err_q <= 1'b1;
              state <= FAIL;
            end
          end
          WAIT_TAG: begin
            if (bus.tag_valid) begin
              auth_done_q <= 1'b1;
              auth_ok_q   <= !tag_diff;
              state       <= tag_diff ? FAIL : RELEASE;
            end
          end
          RELEASE: begin
            if (out_fire) begin
              rd_ptr <= rd_ptr + 1'b1;
              count  <= count - 1'b1;
              if (mem_last[rd_ptr]) begin
                count <= '0;
                state <= IDLE;
              end
            end
          end
          FAIL: begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ascon_dec_release_buffer.sv
// Scoreboard bench for the release buffer: directed messages, tag checks, abort paths.
// Expected blocks are staged on send and committed to the scoreboard on a matching tag.
module tb_ascon_dec_release_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_dec_release_buffer_if bus ();

  ascon_dec_release_buffer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [4:0]   b;
    logic         l;
  } blk_t;

  localparam logic [127:0] TAG = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D0  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D1  = 128'hDEADBEEF0000111122223333CAFEF00D;
  localparam logic [127:0] D2  = 128'h000000000000000000000000A5A5A5A5;

  blk_t stage_q[$];
  blk_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [133:0] act,
                     input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic [4:0] b,
                      input logic l);
    int n;
    blk_t e;
    n = 0;
    bus.pt_valid = 1'b1;
    bus.pt_data  = d;
    bus.pt_bytes = b;
    bus.pt_last  = l;
    while (!bus.pt_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got pt_ready=0 want 1");
    end
    tick();
    bus.pt_valid = 1'b0;
    e.d = d;
    e.b = b;
    e.l = l;
    stage_q.push_back(e);
  endtask

  task automatic tag_check(input logic [127:0] calc, input logic [127:0] rx,
                           input logic ok);
    bus.tag_calc  = calc;
    bus.tag_rx    = rx;
    bus.tag_valid = 1'b1;
    tick();
    bus.tag_valid = 1'b0;
    if (ok)
      while (stage_q.size() > 0) exp_q.push_back(stage_q.pop_front());
    else
      stage_q.delete();
    chk("auth_done_pulse", bus.auth_done, 1'b1);
    chk("auth_ok", bus.auth_ok, ok);
    chk("latency_out_valid", bus.out_valid, ok);
  endtask

  task automatic drain(input int want);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_cycles", n, want);
    chk("idle_pt_ready", bus.pt_ready, 1'b0);
    chk("idle_out_valid", bus.out_valid, 1'b0);
  endtask

  // Monitor: pops and compares every accepted output beat; checks hold under stall.
  initial begin
    logic stall;
    blk_t held;
    blk_t cur;
    blk_t e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst || bus.start) begin
        stall = 1'b0;
      end else begin
        cur.d = bus.out_data;
        cur.b = bus.out_bytes;
        cur.l = bus.out_last;
        if (stall) begin
          chk("hold_valid", bus.out_valid, 1'b1);
          chk("hold_beat", cur, held);
        end
        if (!bus.out_valid) begin
          chk("idle_zero", cur, '0);
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got %h want none", cur);
        end else if (bus.out_ready) begin
          e = exp_q.pop_front();
          chk("out_beat", cur, e);
        end
        stall = bus.out_valid && !bus.out_ready;
        held  = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] first;
    bus.start     = 1'b0;
    bus.pt_valid  = 1'b0;
    bus.pt_data   = '0;
    bus.pt_bytes  = '0;
    bus.pt_last   = 1'b0;
    bus.tag_valid = 1'b0;
    bus.tag_calc  = '0;
    bus.tag_rx    = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_pt_ready", bus.pt_ready, 1'b0);
    chk("rst_out", {bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last}, '0);
    chk("rst_flags", {bus.auth_done, bus.auth_ok, bus.err_overflow}, '0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("idle_no_ready", bus.pt_ready, 1'b0);

    // matched message, out_ready high throughout
    do_start();
    chk("start_ready", bus.pt_ready, 1'b1);
    send(D0, 5'd16, 1'b0);
    send(D1, 5'd16, 1'b0);
    send(D2, 5'd5, 1'b1);
    chk("wait_tag_no_ready", bus.pt_ready, 1'b0);
    tag_check(TAG, TAG, 1'b1);
    drain(3);
    chk("auth_ok_hold", bus.auth_ok, 1'b1);
    chk("auth_done_low", bus.auth_done, 1'b0);

    // tag differs in bit 0 only
    do_start();
    chk("start_clears_ok", bus.auth_ok, 1'b0);
    send(D0, 5'd16, 1'b0);
    send(D1, 5'd16, 1'b0);
    send(D2, 5'd5, 1'b1);
    tag_check(TAG, TAG ^ 128'd1, 1'b0);
    tick();
    chk("fail_idle_ready", bus.pt_ready, 1'b0);
    chk("fail_out_valid", bus.out_valid, 1'b0);
    chk("fail_auth_ok", bus.auth_ok, 1'b0);
    chk("fail_done_low", bus.auth_done, 1'b0);

    // overflow: five blocks into a four-deep buffer
    do_start();
    send(D0, 5'd16, 1'b0);
    send(D1, 5'd16, 1'b0);
    send(D2, 5'd16, 1'b0);
    send(TAG, 5'd16, 1'b0);
    stage_q.delete();
    chk("full_no_ready", bus.pt_ready, 1'b0);
    bus.pt_valid = 1'b1;
    tick();
    bus.pt_valid = 1'b0;
    chk("overflow_flag", bus.err_overflow, 1'b1);
    chk("overflow_no_out", bus.out_valid, 1'b0);
    tick();
    chk("overflow_sticky", bus.err_overflow, 1'b1);
    chk("overflow_idle", bus.pt_ready, 1'b0);

    // back-pressure for 10 cycles
    do_start();
    chk("start_clears_err", bus.err_overflow, 1'b0);
    bus.out_ready = 1'b0;
    send(D0, 5'd16, 1'b0);
    send(D1, 5'd16, 1'b0);
    send(D2, 5'd5, 1'b1);
    tag_check(TAG, TAG, 1'b1);
    first = bus.out_data;
    chk("stall_first", first, D0);
    repeat (10) begin
      tick();
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_data", bus.out_data, first);
    end
    bus.out_ready = 1'b1;
    drain(3);

    // reset in the middle of release
    do_start();
    bus.out_ready = 1'b0;
    send(D0, 5'd16, 1'b0);
    send(D1, 5'd16, 1'b0);
    send(D2, 5'd5, 1'b1);
    tag_check(TAG, TAG, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("mid_release_valid", bus.out_valid, 1'b1);
    chk("mid_release_data", bus.out_data, D1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_out", {bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last}, '0);
    chk("arst_flags", {bus.pt_ready, bus.auth_done, bus.auth_ok, bus.err_overflow}, '0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_out", bus.out_valid, 1'b0);

    // abort in WAIT_TAG, then a one-block zero-length message
    do_start();
    send(D1, 5'd16, 1'b0);
    send(D2, 5'd7, 1'b1);
    stage_q.delete();
    do_start();
    chk("abort_ready", bus.pt_ready, 1'b1);
    chk("abort_auth_ok", bus.auth_ok, 1'b0);
    send(TAG, 5'd0, 1'b1);
    tag_check(TAG, TAG, 1'b1);
    chk("zero_len_bytes", bus.out_bytes, 5'd0);
    chk("zero_len_last", bus.out_last, 1'b1);
    drain(1);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ascon_dec_release_buffer.md
ASCON_DEC_RELEASE_BUFFER -- requirements
Module: ascon_dec_release_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning plaintext block capacity; legal values are powers of two >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin new message; clears buffer and flags.
REQ-005 SHALL have ports pt_valid input 1 and pt_ready output 1, the plaintext-in handshake from the decrypting core.
REQ-006 SHALL have port pt_data  input  128  decrypted plaintext block.
REQ-007 SHALL have port pt_bytes  input  5  valid bytes in block, 0..16.
REQ-008 SHALL have port pt_last  input  1  block is the final data block of the message.
REQ-009 SHALL have ports tag_valid input 1, tag_calc input 128 (tag computed by core) and tag_rx input 128 (tag received with ciphertext).
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_data output 128, out_bytes output 5 and out_last output 1, the released-plaintext handshake.
REQ-011 SHALL have ports auth_done output 1 (one-cycle pulse at tag decision), auth_ok output 1 (decision level) and err_overflow output 1 (sticky).

Function
REQ-012 SHALL implement FSM states IDLE, COLLECT, WAIT_TAG, RELEASE and FAIL.
REQ-013 SHALL never present any plaintext on out_* before the tag has matched; out_data and out_bytes SHALL be zero whenever out_valid is 0.
REQ-014 In IDLE, start SHALL clear count, read/write pointers, auth_ok and err_overflow, and SHALL go to COLLECT next cycle; pt_ready SHALL be 0 in IDLE.
REQ-015 pt_ready SHALL equal (state==COLLECT && count<DEPTH), combinationally.
REQ-016 A pt_valid&&pt_ready cycle SHALL write {pt_data,pt_bytes,pt_last} at the write pointer, increment the pointer modulo DEPTH and increment count.
REQ-017 An accepted block with pt_last=1 SHALL move COLLECT->WAIT_TAG next cycle.
REQ-018 In COLLECT with count==DEPTH and pt_valid=1, SHALL set err_overflow=1 and go to FAIL.
REQ-019 In WAIT_TAG, tag_valid SHALL compare all 128 bits by OR-reduction of tag_calc XOR tag_rx (no early exit) and pulse auth_done for exactly one cycle.
REQ-020 On match, SHALL set auth_ok=1 and go to RELEASE; on mismatch, SHALL set auth_ok=0 and go to FAIL.
REQ-021 tag_valid outside WAIT_TAG SHALL be ignored.
REQ-022 In RELEASE, out_valid SHALL be (count>0), out_* SHALL show the entry at the read pointer, and out_valid&&out_ready SHALL pop one entry (pointer modulo DEPTH).
REQ-023 out_last SHALL be 1 only on the final stored block; its pop SHALL return to IDLE next cycle.
REQ-024 out_valid SHALL stay asserted with stable out_* until accepted (no retraction under back-pressure).
REQ-025 FAIL SHALL zero count and pointers, keep out_valid=0 and go to IDLE next cycle; buffer contents SHALL NOT be readable afterwards.
REQ-026 start in COLLECT, WAIT_TAG or RELEASE SHALL abort the message: clear as in REQ-014 and enter COLLECT next cycle; a same-cycle pt or out handshake is discarded.
REQ-027 auth_ok and err_overflow SHALL hold their value until the next start or reset.
REQ-028 Latency: first out_valid SHALL rise the cycle after the matching tag_valid cycle.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, count=0, pointers=0, pt_ready=0, out_valid=0, out_data=0, out_bytes=0, out_last=0, auth_done=0, auth_ok=0, err_overflow=0, regardless of clk.
REQ-030 rst asserted mid-RELEASE SHALL drop out_valid asynchronously; no buffered block SHALL appear after deassertion.

Verification
REQ-031 start; 3 blocks (pt_bytes=16,16,5; last on third); tag_calc=tag_rx=128'h0123...CDEF -> auth_done pulse, auth_ok=1, 3 blocks out in order, out_last on third, out_bytes=5, then IDLE.
REQ-032 Same stream, tag_rx differs only in bit 0 -> auth_done pulse, auth_ok=0, out_valid never 1, state IDLE after FAIL.
REQ-033 DEPTH=4; 4 non-last blocks then 5th pt_valid -> pt_ready=0 after 4th, err_overflow=1, FAIL, no output.
REQ-034 Matched tag, out_ready held 0 for 10 cycles then 1 -> out_valid and out_data stable for 10 cycles, then one pop per cycle.
REQ-035 rst pulse mid-RELEASE after 1 of 3 pops, and start mid-WAIT_TAG -> all outputs zero per REQ-029; after start, next message of 1 block with pt_bytes=0 releases correctly.
